// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and per-program address tables for fetch_sequencer.
//   br_mode_e : branch mode decoded from BrMode (abs-cond, rel-cond, call, return)
//   state_e   : sequencer FSM states
//   START_ADDR/HALT_ADDR : entry and final PC of each selectable program
package fetch_pkg;

  localparam int FETCH_PC_W       = 10;
  localparam int FETCH_NUM_PROGS  = 4;
  localparam int FETCH_LINK_DEPTH = 4;

  typedef enum logic [1:0] {
    BR_ABS  = 2'b00,
    BR_REL  = 2'b01,
    BR_CALL = 2'b10,
    BR_RET  = 2'b11
  } br_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_HALTED  = 2'b10
  } state_e;

  // Program map for the default build (PC_W=10, four programs).
  localparam logic [FETCH_PC_W-1:0] START_ADDR [FETCH_NUM_PROGS] =
    '{10'h000, 10'h100, 10'h200, 10'h300};
  localparam logic [FETCH_PC_W-1:0] HALT_ADDR [FETCH_NUM_PROGS] =
    '{10'h031, 10'h10F, 10'h2FF, 10'h30F};

endpackage

// File: rtl/fetch_sequencer_link_stack.sv
// link_stack: small LIFO holding return addresses.
//   CLK     : clock
//   clr_i   : synchronous clear of the pointer (contents become don't-care)
//   push_i  : write din_i at the top (ignored when full)
//   pop_i   : drop the top entry (ignored when empty)
//   din_i   : value to push
//   top_o   : current top entry, combinational
//   full_o  : DEPTH entries held
//   empty_o : no entries held
module link_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic             CLK,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] top_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_idx, rd_idx;

  assign full_o  = (ptr_q == PTR_W'(DEPTH));
  assign empty_o = (ptr_q == '0);
  assign wr_idx  = ptr_q[ADDR_W-1:0];
  // Wraps correctly when full: low bits are 0, minus one gives DEPTH-1.
  assign rd_idx  = ptr_q[ADDR_W-1:0] - ADDR_W'(1);
  assign top_o   = mem_q[rd_idx];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (push_i && !full_o) begin
      ptr_d = ptr_q + PTR_W'(1);
    end else if (pop_i && !empty_o) begin
      ptr_d = ptr_q - PTR_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    ptr_q <= ptr_d;
  end

  // NOTE: the storage array is deliberately not reset; only the pointer defines validity.
  always_ff @(posedge CLK) begin
    if (!clr_i && push_i && !full_o) begin
      mem_q[wr_idx] <= din_i;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: next-PC generator for instruction fetch.
//   CLK, Init       : clock and synchronous active-high reset
//   Start, ProgSel  : launch program ProgSel from its start address
//   Stall           : freeze everything this cycle (Start still wins)
//   Branch_en, FLAG_IN, BrMode, Target : branch/call/return request
//   PC              : registered fetch address
//   Halt, Running   : sticky program-finished flag, FSM-in-RUN flag
//   StackErr        : sticky link-stack overflow/underflow
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int PC_W       = FETCH_PC_W,
  parameter int NUM_PROGS  = FETCH_NUM_PROGS,
  parameter int LINK_DEPTH = FETCH_LINK_DEPTH
) (
  input  logic                         CLK,
  input  logic                         Init,
  input  logic                         Start,
  input  logic [$clog2(NUM_PROGS)-1:0] ProgSel,
  input  logic                         Stall,
  input  logic                         Branch_en,
  input  logic                         FLAG_IN,
  input  logic [1:0]                   BrMode,
  input  logic [PC_W-1:0]              Target,
  output logic [PC_W-1:0]              PC,
  output logic                         Halt,
  output logic                         Running,
  output logic                         StackErr
);

  localparam int PROG_W = $clog2(NUM_PROGS);

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PROG_W-1:0]  prog_q, prog_d;
  logic               halt_q, halt_d;
  logic               err_q, err_d;

  logic               push, pop;
  logic [PC_W-1:0]    stk_top;
  logic               stk_full, stk_empty;
  logic [PC_W-1:0]    pc_inc;
  logic               taken;
  br_mode_e           mode;

  assign pc_inc = pc_q + PC_W'(1);
  assign mode   = br_mode_e'(BrMode);

  link_stack #(
    .DEPTH (LINK_DEPTH),
    .WIDTH (PC_W)
  ) u_link_stack (
    .CLK     (CLK),
    .clr_i   (Init | Start),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (pc_inc),
    .top_o   (stk_top),
    .full_o  (stk_full),
    .empty_o (stk_empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    prog_d  = prog_q;
    halt_d  = halt_q;
    err_d   = err_q;
    push    = 1'b0;
    pop     = 1'b0;
    taken   = 1'b0;

    if (Start) begin
      state_d = ST_RUN;
      pc_d    = PC_W'(START_ADDR[ProgSel]);
      prog_d  = ProgSel;
      halt_d  = 1'b0;
      err_d   = 1'b0;
    end else if (state_q == ST_RUN && !Stall) begin
      if (Branch_en) begin
        unique case (mode)
          BR_ABS: if (FLAG_IN) begin
            taken = 1'b1;
            pc_d  = Target;
          end
          BR_REL: if (FLAG_IN) begin
            taken = 1'b1;
            pc_d  = pc_q + Target;  // two's-complement offset, wraps naturally
          end
          BR_CALL: begin
            taken = 1'b1;
            pc_d  = Target;
            if (stk_full) err_d = 1'b1;
            else          push  = 1'b1;
          end
          BR_RET: begin
            // Underflowing return falls through but still counts as taken.
            taken = 1'b1;
            if (stk_empty) begin
              err_d = 1'b1;
              pc_d  = pc_inc;
            end else begin
              pop  = 1'b1;
              pc_d = stk_top;
            end
          end
          default: ;
        endcase
      end
      if (!taken) begin
        if (pc_q == PC_W'(HALT_ADDR[prog_q])) begin
          state_d = ST_HALTED;
          halt_d  = 1'b1;
        end else begin
          pc_d = pc_inc;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Init) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      prog_q  <= '0;
      halt_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      prog_q  <= prog_d;
      halt_q  <= halt_d;
      err_q   <= err_d;
    end
  end

  assign PC       = pc_q;
  assign Halt     = halt_q;
  assign Running  = (state_q == ST_RUN);
  assign StackErr = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: table-driven vectors plus
// hand-written multi-cycle sequences, all routed through a scoreboard queue.
module tb_fetch_sequencer;

  localparam int PC_W       = 10;
  localparam int NUM_PROGS  = 4;
  localparam int LINK_DEPTH = 4;

  localparam logic [1:0] M_ABS  = 2'b00;
  localparam logic [1:0] M_REL  = 2'b01;
  localparam logic [1:0] M_CALL = 2'b10;
  localparam logic [1:0] M_RET  = 2'b11;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            halt;
    logic            run;
    logic            err;
  } exp_t;

  typedef struct packed {
    logic            init;
    logic            start;
    logic [1:0]      sel;
    logic            stall;
    logic            ben;
    logic            flag;
    logic [1:0]      mode;
    logic [PC_W-1:0] target;
    exp_t            exp;
  } vec_t;

  logic            CLK = 1'b0;
  logic            Init = 1'b0, Start = 1'b0, Stall = 1'b0;
  logic [1:0]      ProgSel = '0;
  logic            Branch_en = 1'b0, FLAG_IN = 1'b0;
  logic [1:0]      BrMode = '0;
  logic [PC_W-1:0] Target = '0;
  logic [PC_W-1:0] PC;
  logic            Halt, Running, StackErr;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  fetch_sequencer #(
    .PC_W       (PC_W),
    .NUM_PROGS  (NUM_PROGS),
    .LINK_DEPTH (LINK_DEPTH)
  ) dut (
    .CLK       (CLK),
    .Init      (Init),
    .Start     (Start),
    .ProgSel   (ProgSel),
    .Stall     (Stall),
    .Branch_en (Branch_en),
    .FLAG_IN   (FLAG_IN),
    .BrMode    (BrMode),
    .Target    (Target),
    .PC        (PC),
    .Halt      (Halt),
    .Running   (Running),
    .StackErr  (StackErr)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t e(input logic [PC_W-1:0] pc, input logic halt,
                             input logic run, input logic err);
    e = '{pc: pc, halt: halt, run: run, err: err};
  endfunction

  function automatic vec_t v(input logic init, input logic start, input logic [1:0] sel,
                             input logic stall, input logic ben, input logic flag,
                             input logic [1:0] mode, input logic [PC_W-1:0] target,
                             input exp_t ex);
    v = '{init: init, start: start, sel: sel, stall: stall, ben: ben, flag: flag,
          mode: mode, target: target, exp: ex};
  endfunction

  task automatic check(input string name, input exp_t got, input exp_t want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got pc=%h halt=%b run=%b err=%b, want pc=%h halt=%b run=%b err=%b",
               name, got.pc, got.halt, got.run, got.err,
               want.pc, want.halt, want.run, want.err);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
  task automatic apply(input string name, input vec_t vv);
    exp_t got, want;
    @(negedge CLK);
    Init      = vv.init;
    Start     = vv.start;
    ProgSel   = vv.sel;
    Stall     = vv.stall;
    Branch_en = vv.ben;
    FLAG_IN   = vv.flag;
    BrMode    = vv.mode;
    Target    = vv.target;
    sb_q.push_back(vv.exp);
    @(posedge CLK);
    #1;
    got = '{pc: PC, halt: Halt, run: Running, err: StackErr};
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      want = sb_q.pop_front();
      check(name, got, want);
    end
  endtask

  task automatic idle_cycle(input string name, input exp_t ex);
    apply(name, v(0, 0, 0, 0, 0, 0, M_ABS, '0, ex));
  endtask

  vec_t vecs[32];

  initial begin
    // Main table: one continuous scenario from reset.
    vecs[0]  = v(1, 0, 0, 0, 0, 0, M_ABS,  10'h000, e(10'h000, 0, 0, 0)); // reset
    vecs[1]  = v(0, 0, 0, 0, 1, 1, M_ABS,  10'h055, e(10'h000, 0, 0, 0)); // branch ignored in IDLE
    vecs[2]  = v(0, 1, 0, 0, 0, 0, M_ABS,  10'h000, e(10'h000, 0, 1, 0)); // start prog 0
    vecs[3]  = v(0, 0, 0, 0, 0, 0, M_ABS,  10'h000, e(10'h001, 0, 1, 0));
    vecs[4]  = v(0, 0, 0, 0, 1, 1, M_ABS,  10'h010, e(10'h010, 0, 1, 0));
    vecs[5]  = v(0, 0, 0, 0, 1, 1, M_REL,  10'h3FC, e(10'h00C, 0, 1, 0)); // rel -4 taken
    vecs[6]  = v(0, 0, 0, 0, 1, 0, M_ABS,  10'h200, e(10'h00D, 0, 1, 0)); // abs not taken
    vecs[7]  = v(0, 0, 0, 0, 1, 1, M_ABS,  10'h010, e(10'h010, 0, 1, 0));
    vecs[8]  = v(0, 0, 0, 0, 1, 0, M_REL,  10'h3FC, e(10'h011, 0, 1, 0)); // rel not taken
    vecs[9]  = v(0, 0, 0, 0, 1, 1, M_ABS,  10'h020, e(10'h020, 0, 1, 0));
    vecs[10] = v(0, 0, 0, 0, 1, 0, M_CALL, 10'h100, e(10'h100, 0, 1, 0)); // call ignores flag
    vecs[11] = v(0, 0, 0, 0, 0, 0, M_ABS,  10'h000, e(10'h101, 0, 1, 0));
    vecs[12] = v(0, 0, 0, 0, 1, 0, M_RET,  10'h000, e(10'h021, 0, 1, 0)); // return
    vecs[13] = v(0, 0, 0, 1, 1, 1, M_ABS,  10'h0AA, e(10'h021, 0, 1, 0)); // stall x3
    vecs[14] = v(0, 0, 0, 1, 1, 1, M_ABS,  10'h0AA, e(10'h021, 0, 1, 0));
    vecs[15] = v(0, 0, 0, 1, 1, 1, M_ABS,  10'h0AA, e(10'h021, 0, 1, 0));
    vecs[16] = v(0, 0, 0, 0, 1, 1, M_ABS,  10'h0AA, e(10'h0AA, 0, 1, 0)); // first unstalled edge
    vecs[17] = v(0, 0, 0, 0, 1, 1, M_ABS,  10'h3FE, e(10'h3FE, 0, 1, 0));
    vecs[18] = v(0, 0, 0, 0, 0, 0, M_ABS,  10'h000, e(10'h3FF, 0, 1, 0));
    vecs[19] = v(0, 0, 0, 0, 0, 0, M_ABS,  10'h000, e(10'h000, 0, 1, 0)); // wrap
    vecs[20] = v(0, 0, 0, 0, 1, 1, M_ABS,  10'h123, e(10'h123, 0, 1, 0));
    vecs[21] = v(1, 0, 0, 0, 0, 0, M_ABS,  10'h000, e(10'h000, 0, 0, 0)); // Init mid-RUN
    vecs[22] = v(0, 0, 0, 0, 0, 0, M_ABS,  10'h000, e(10'h000, 0, 0, 0));
    vecs[23] = v(0, 0, 0, 0, 1, 1, M_ABS,  10'h077, e(10'h000, 0, 0, 0));
    vecs[24] = v(0, 1, 1, 0, 0, 0, M_ABS,  10'h000, e(10'h100, 0, 1, 0)); // start prog 1
    vecs[25] = v(0, 0, 0, 0, 0, 0, M_ABS,  10'h000, e(10'h101, 0, 1, 0));
    vecs[26] = v(0, 1, 2, 1, 0, 0, M_ABS,  10'h000, e(10'h200, 0, 1, 0)); // start wins over stall
    vecs[27] = v(0, 0, 0, 1, 0, 0, M_ABS,  10'h000, e(10'h200, 0, 1, 0));
    vecs[28] = v(0, 0, 0, 0, 1, 1, M_ABS,  10'h050, e(10'h050, 0, 1, 0));
    vecs[29] = v(0, 0, 0, 0, 1, 1, M_RET,  10'h000, e(10'h051, 0, 1, 1)); // empty return
    vecs[30] = v(0, 0, 0, 0, 0, 0, M_ABS,  10'h000, e(10'h052, 0, 1, 1)); // sticky error
    vecs[31] = v(0, 1, 0, 0, 0, 0, M_ABS,  10'h000, e(10'h000, 0, 1, 0)); // start clears error

    for (int i = 0; i < 32; i++) begin
      apply($sformatf("vec%0d", i), vecs[i]);
    end

    // Free-run program 0 from 0 to its halt address.
    for (int i = 1; i <= 'h31; i++) begin
      idle_cycle("freerun", e(PC_W'(i), 0, 1, 0));
    end
    idle_cycle("halt_assert", e(10'h031, 1, 0, 0));
    for (int i = 0; i < 5; i++) begin
      apply("halt_hold", v(0, 0, 0, 0, 1, 1, M_ABS, 10'h0F0, e(10'h031, 1, 0, 0)));
    end
    apply("restart", v(0, 1, 0, 0, 0, 0, M_ABS, 10'h000, e(10'h000, 0, 1, 0)));

    // Taken branch at the halt address beats the halt; not-taken one does not.
    apply("p1_start",   v(0, 1, 1, 0, 0, 0, M_ABS, 10'h000, e(10'h100, 0, 1, 0)));
    apply("p1_to_halt", v(0, 0, 0, 0, 1, 1, M_ABS, 10'h10F, e(10'h10F, 0, 1, 0)));
    apply("br_at_halt", v(0, 0, 0, 0, 1, 1, M_ABS, 10'h10A, e(10'h10A, 0, 1, 0)));
    apply("p1_to_halt2", v(0, 0, 0, 0, 1, 1, M_ABS, 10'h10F, e(10'h10F, 0, 1, 0)));
    apply("nt_at_halt", v(0, 0, 0, 0, 1, 0, M_ABS, 10'h10A, e(10'h10F, 1, 0, 0)));

    // Nested calls: LINK_DEPTH pushes succeed, the next overflows but still jumps.
    apply("nest_start", v(0, 1, 0, 0, 0, 0, M_ABS, 10'h000, e(10'h000, 0, 1, 0)));
    for (int i = 0; i <= LINK_DEPTH; i++) begin
      logic [PC_W-1:0] tgt;
      tgt = PC_W'(10'h100 + i * 10'h010);
      apply($sformatf("call%0d", i),
            v(0, 0, 0, 0, 1, 0, M_CALL, tgt, e(tgt, 0, 1, (i == LINK_DEPTH))));
    end
    // Returns unwind call sites LINK_DEPTH-1 .. 0; the overflowed call left no entry.
    for (int i = LINK_DEPTH - 1; i >= 0; i--) begin
      logic [PC_W-1:0] ret_pc;
      ret_pc = (i == 0) ? PC_W'(1) : PC_W'(10'h101 + (i - 1) * 10'h010);
      apply($sformatf("ret%0d", i),
            v(0, 0, 0, 0, 1, 0, M_RET, 10'h000, e(ret_pc, 0, 1, 1)));
    end

    if (sb_q.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Parametrised instruction-fetch sequencer: next-generation program counter for the basic processor. It adds multi-program start/halt selection, absolute and PC-relative conditional branches, call/return through a small link stack, a fetch stall, and a halt that holds until an explicit restart. It sits between decode/branch logic and instruction memory, driving the fetch address each cycle.

## Interface
Parameters:
- PC_W, 10, program-counter width in bits
- NUM_PROGS, 4, number of selectable programs (power of two, ≥2)
- LINK_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- CLK  in  1  clock; all state changes on posedge only
- Init  in  1  reset, synchronous, active-high
- Start  in  1  one-cycle pulse: begin executing program ProgSel
- ProgSel  in  $clog2(NUM_PROGS)  program index, sampled only when Start=1
- Stall  in  1  hold PC and all state this cycle
- Branch_en  in  1  branch/call/return instruction in decode
- FLAG_IN  in  1  condition flag for conditional modes
- BrMode  in  2  00 abs-cond, 01 rel-cond, 10 call, 11 return
- Target  in  PC_W  absolute target, or two's-complement offset in mode 01
- PC  out  PC_W  fetch address
- Halt  out  1  program finished; sticky
- Running  out  1  FSM in RUN
- StackErr  out  1  sticky link-stack overflow/underflow

## Operation
- FSM states IDLE, RUN, HALTED. Init: state IDLE, PC=0, Halt=0, Running=0, StackErr=0, stack pointer 0, current program 0.
- Priority each cycle: Init > Start > Stall > branch > halt check > increment.
- Start (any state): state RUN, PC=START_ADDR[ProgSel], cur_prog=ProgSel, Halt=0, stack pointer cleared, StackErr cleared. Start during Stall still restarts.
- IDLE/HALTED without Start: PC and Halt hold; Branch_en ignored.
- RUN, Stall=1: nothing changes (PC, stack, state, flags).
- RUN, Branch_en=1:
  - 00: FLAG_IN ? PC=Target : PC+1.
  - 01: FLAG_IN ? PC=PC+Target (signed, modulo 2^PC_W) : PC+1.
  - 10: unconditional; push PC+1, PC=Target. Stack full: no push, StackErr=1, jump still taken.
  - 11: unconditional; pop, PC=popped value. Stack empty: StackErr=1, PC=PC+1.
- RUN, no taken branch, PC==HALT_ADDR[cur_prog]: state HALTED, Halt=1, PC holds at the halt address. A taken branch at the halt address takes priority (no halt).
- Otherwise PC=PC+1, wrapping 2^PC_W−1 → 0.
- Running = (state==RUN).

## Timing
- All outputs registered; every effect visible the cycle after the qualifying edge.
- Branch/call/return: 1-cycle latency, no bubble inserted by this block.
- Halt asserts the cycle after the halt-address PC is presented; it stays asserted until Start or Init.
- A call and its stack push commit on the same edge. A return reads the top entry combinationally and decrements the pointer on the same edge.
- Init mid-RUN aborts immediately. Stack contents become don't-care; only the pointer is cleared.

## Structure
- Package fetch_pkg: BrMode enum (BR_ABS, BR_REL, BR_CALL, BR_RET), state enum, and START_ADDR/HALT_ADDR constant arrays (NUM_PROGS entries, PC_W wide). Defaults for program 0 are start 0 and halt 10'h031.
- Sub-module link_stack: parametrised LIFO (depth, width) with push, pop, full, empty, top; synchronous clear on Init or Start.

## Test plan
- Init, then Start with ProgSel=0 → PC=0 the next cycle, Running=1. Free-run to 10'h031 → next cycle Halt=1, PC stays 10'h031 for 5 cycles. Start again → Halt=0, PC=0.
- RUN at PC=10'h010, BrMode=01, Target=10'h3FC (−4), FLAG_IN=1 → PC=10'h00C. Same with FLAG_IN=0 → PC=10'h011.
- At PC=10'h020, call Target=10'h100 → PC=10'h100. Later return → PC=10'h021, StackErr=0.
- Make LINK_DEPTH+1 nested calls → last call jumps but StackErr=1. Return on an empty stack at PC=10'h050 → PC=10'h051, StackErr=1.
- Stall held 3 cycles with Branch_en=1, BrMode=00, FLAG_IN=1 → PC unchanged. The branch is taken on the first unstalled edge.
- PC=10'h3FF with no branch → PC=10'h000. Init asserted mid-RUN at PC=10'h123 → PC=0, state IDLE, PC holds without Start.
